// File: rtl/stream_frame_packer_pkg.sv
// Shared definitions for the stream frame packer.
// State encoding, word layout constants and checksum fold helper.
package stream_frame_packer_pkg;

    localparam int WORD_W   = 33;
    localparam int LAST_BIT = 32;

    localparam logic [15:0] TRL_TAG_DEF = 16'hA5C3;

    typedef enum logic [1:0] {
        PAYLOAD  = 2'd0,
        TRL_LEN  = 2'd1,
        TRL_CSUM = 2'd2
    } state_e;

    function automatic logic [31:0] csum_fold(
        input logic [31:0] sum,
        input logic [31:0] xr
    );
        return sum ^ {xr[15:0], xr[31:16]};
    endfunction

endpackage

// File: rtl/stream_frame_packer_out_buf.sv
// Two-entry output FIFO for the frame packer.
// Head drives the port; reports occupancy after this cycle's pop.
module frame_out_buf
    import stream_frame_packer_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    output logic [1:0]        occ_post_o
);

    logic [WORD_W-1:0] ent0_q, ent0_d;
    logic [WORD_W-1:0] ent1_q, ent1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = out_valid_o ? ent0_q : '0;
    assign pop         = out_valid_o & out_ready_i;
    assign occ_post_o  = cnt_q - {1'b0, pop};

    // Shift head on pop, then write into the first free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = occ_post_o + {1'b0, push_i};
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (push_i) begin
            if (occ_post_o == 2'd0) begin
                ent0_d = push_data_i;
            end else begin
                ent1_d = push_data_i;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_frame_packer.sv
// Frame packer: re-emits FIFO words as frames with a
// length word and a checksum word appended to each frame.
module stream_frame_packer
    import stream_frame_packer_pkg::*;
#(
    parameter int          MAX_WORDS = 1024,
    parameter int          LEN_W     = 11,
    parameter logic [15:0] TRL_TAG   = TRL_TAG_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              frame_done,
    output logic              err_overlong
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d, count_inc;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       xr_q, xr_d;
    logic              cap_pend_q;
    logic              run_q;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic [1:0]        occ_post;
    logic              cap_last;

    frame_out_buf u_buf (
        .clk         (clk),
        .nrst        (nrst),
        .push_i      (push),
        .push_data_i (push_data),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .occ_post_o  (occ_post)
    );

    assign count_inc = count_q + LEN_W'(1);

    // Accept only when a slot is reserved for every word in flight.
    assign in_ready = run_q & (state_q == PAYLOAD) & ~cap_last &
                      (({1'b0, occ_post} + {2'b0, cap_pend_q}) < 3'd2);

    assign frame_done = out_valid & out_ready & out_data[LAST_BIT];

    // Next-state, datapath update and buffer push selection.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sum_d        = sum_q;
        xr_d         = xr_q;
        push         = 1'b0;
        push_data    = '0;
        cap_last     = 1'b0;
        err_overlong = 1'b0;
        unique case (state_q)
            PAYLOAD: begin
                if (cap_pend_q) begin
                    push      = 1'b1;
                    push_data = {1'b0, in_data[31:0]};
                    count_d   = count_inc;
                    sum_d     = sum_q + in_data[31:0];
                    xr_d      = xr_q ^ in_data[31:0];
                    if (in_data[LAST_BIT] ||
                        count_inc == LEN_W'(MAX_WORDS)) begin
                        cap_last     = 1'b1;
                        err_overlong = ~in_data[LAST_BIT];
                        state_d      = TRL_LEN;
                    end
                end
            end
            TRL_LEN: begin
                if (occ_post != 2'd2) begin
                    push      = 1'b1;
                    push_data = {1'b0, TRL_TAG, 16'(count_q)};
                    state_d   = TRL_CSUM;
                end
            end
            TRL_CSUM: begin
                if (occ_post != 2'd2) begin
                    push      = 1'b1;
                    push_data = {1'b1, csum_fold(sum_q, xr_q)};
                    count_d   = '0;
                    sum_d     = '0;
                    xr_d      = '0;
                    state_d   = PAYLOAD;
                end
            end
            default: state_d = PAYLOAD;
        endcase
    end

    // State, running length/checksum and capture-pending flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= PAYLOAD;
            count_q    <= '0;
            sum_q      <= '0;
            xr_q       <= '0;
            cap_pend_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            xr_q       <= xr_d;
            cap_pend_q <= in_valid & in_ready;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_frame_packer.sv
// Scoreboard bench for stream_frame_packer.
// Stimulus pushes expected words; a monitor pops and compares.
module tb_stream_frame_packer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_data;
    logic        frame_done;
    logic        err_overlong;

    stream_frame_packer dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .frame_done   (frame_done),
        .err_overlong (err_overlong)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [32:0] src_q[$];
    logic [32:0] exp_q[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          rdy_mode = 0;
    bit          vld_rand = 0;
    bit          auto_exp = 0;
    bit          hs_prev = 0;
    logic [32:0] hs_word = '0;
    int          m_cnt = 0;
    logic [31:0] m_sum = '0;
    logic [31:0] m_xr = '0;
    int          n_done_exp = 0;
    int          n_err_exp = 0;
    int          n_done = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic exp_trailer(input int len, input logic [31:0] csum);
        exp_q.push_back({1'b0, 16'hA5C3, 16'(len)});
        exp_q.push_back({1'b1, csum});
        n_done_exp++;
    endtask

    // Reference model of the framing rules, used for long/random traffic.
    task automatic model(input logic [32:0] w);
        m_cnt++;
        m_sum = m_sum + w[31:0];
        m_xr  = m_xr ^ w[31:0];
        exp_q.push_back({1'b0, w[31:0]});
        if (w[32] || m_cnt == 1024) begin
            if (!w[32]) n_err_exp++;
            exp_trailer(m_cnt, m_sum ^ {m_xr[15:0], m_xr[31:16]});
            m_cnt = 0;
            m_sum = '0;
            m_xr  = '0;
        end
    endtask

    // One clock: drive at +1 after the edge, sample handshake 3 before next.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        in_data  = hs_prev ? hs_word : {1'($urandom), 32'($urandom)};
        in_valid = (src_q.size() != 0) &&
                   (vld_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
        #6;
        hs_prev = in_valid && in_ready;
        if (hs_prev) begin
            hs_word = src_q.pop_front();
            hs_cyc.push_back(cyc);
            if (auto_exp) model(hs_word);
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((src_q.size() != 0 || hs_prev || exp_q.size() != 0) &&
               n < budget) begin
            tick();
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s drain: %0d words outstanding, required 0",
                     nm, exp_q.size() + src_q.size());
        end
        repeat (3) tick();
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        bit          held_v = 0;
        logic [32:0] held_d = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                held_v = 0;
            end else begin
                if (held_v) chk("hold", {out_valid, out_data}, {1'b1, held_d});
                held_v = out_valid && !out_ready;
                held_d = out_data;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", out_data, 33'h0);
                        chk("unexpected_valid", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e);
                        chk("frame_done", frame_done, e[32]);
                    end
                end
                if (frame_done) n_done++;
                if (err_overlong) n_err++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nrst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 33'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_err", err_overlong, 1'b0);
        nrst = 1'b1;

        // 1) three-word frame at full rate
        hs_cyc.delete();
        src_q = '{{1'b0, 32'h1}, {1'b0, 32'h2}, {1'b1, 32'h3}};
        exp_q.push_back({1'b0, 32'h1});
        exp_q.push_back({1'b0, 32'h2});
        exp_q.push_back({1'b0, 32'h3});
        exp_trailer(3, 32'h0000_0006);
        drain("t1", 50);
        chk("t1_full_rate", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);

        // 2) single all-ones word
        src_q.push_back({1'b1, 32'hFFFF_FFFF});
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        exp_trailer(1, 32'h0000_0000);
        drain("t2", 50);

        // 5) back-to-back frames: trailer gap on the input side
        hs_cyc.delete();
        src_q = '{{1'b0, 32'h10}, {1'b1, 32'h20}, {1'b1, 32'h30}};
        exp_q.push_back({1'b0, 32'h10});
        exp_q.push_back({1'b0, 32'h20});
        exp_trailer(2, 32'h0030_0030);
        exp_q.push_back({1'b0, 32'h30});
        exp_trailer(1, 32'h0030_0030);
        drain("t5", 50);
        chk("t5_pair_rate", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
        chk("t5_trailer_gap", 64'(hs_cyc[2] - hs_cyc[1]), 64'd4);

        // 3) 1025 words without last: forced cut at 1024
        for (int i = 1; i <= 1025; i++) begin
            src_q.push_back({(i == 1025), 32'(i)});
        end
        for (int i = 1; i <= 1024; i++) begin
            exp_q.push_back({1'b0, 32'(i)});
        end
        exp_trailer(1024, 32'h0408_0200);
        exp_q.push_back({1'b0, 32'h401});
        exp_trailer(1, 32'h0401_0401);
        n_err_exp++;
        drain("t3", 1200);
        chk("t3_err_pulses", 64'(n_err), 64'(n_err_exp));

        // 4) random frames, random valid and ready
        auto_exp = 1;
        rdy_mode = 1;
        vld_rand = 1;
        for (int f = 0; f < 50; f++) begin
            int len = $urandom_range(1, 6);
            for (int k = 1; k <= len; k++) begin
                src_q.push_back({(k == len), 32'($urandom)});
            end
        end
        drain("t4", 5000);

        // 6) reset with buffer full mid-payload
        rdy_mode = 2;
        vld_rand = 0;
        for (int i = 1; i <= 6; i++) begin
            src_q.push_back({1'b0, 32'(i + 100)});
        end
        repeat (8) tick();
        chk("t6_full_valid", out_valid, 1'b1);
        chk("t6_full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_out_data", out_data, 33'h0);
        chk("t6_rst_in_ready", in_ready, 1'b0);
        chk("t6_rst_frame_done", frame_done, 1'b0);
        chk("t6_rst_err", err_overlong, 1'b0);
        src_q.delete();
        exp_q.delete();
        hs_prev = 0;
        m_cnt = 0;
        m_sum = '0;
        m_xr  = '0;
        tick();
        tick();
        nrst = 1'b1;
        auto_exp = 0;
        rdy_mode = 0;
        src_q = '{{1'b0, 32'h7}, {1'b1, 32'h9}};
        exp_q.push_back({1'b0, 32'h7});
        exp_q.push_back({1'b0, 32'h9});
        exp_trailer(2, 32'h000E_0010);
        drain("t6", 50);

        chk("frame_done_total", 64'(n_done), 64'(n_done_exp));
        chk("err_overlong_total", 64'(n_err), 64'(n_err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
